// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the BCD-to-binary number encoder.
//   bcd_digit_t   : one packed BCD digit (4 bits)
//   enc_state_t   : encoder FSM states (IDLE, CONV, DONE)
//   BCD_MAX_DIGIT : largest legal decimal digit value
//   cnt_width()   : width of the digit counter for a given digit count
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } enc_state_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

  // A single-digit word still needs a one-bit counter.
  function automatic int cnt_width(input int n_digits);
    return (n_digits > 1) ? $clog2(n_digits) : 1;
  endfunction

endpackage

// File: rtl/bcd_mac_step.sv
// ---------------------------------------------------------------------------
// bcd_mac_step
// Combinational multiply-accumulate step: o_acc_out = (i_acc_in*10 + digit)
// modulo 2^OUT_W.
// Optional feature macro: BCD_DIGIT_CHECK_EN
//   defined   : digits above 9 raise o_bad and are clamped to 9
//   undefined : digits used raw, o_bad tied to 0
// Ports:
//   i_acc_in  [OUT_W] : running accumulator
//   i_digit   [4]     : digit being consumed
//   o_acc_out [OUT_W] : updated accumulator
//   o_bad             : digit was not a legal decimal digit
// ---------------------------------------------------------------------------
module bcd_mac_step
  import bcd_pkg::*;
#(
  parameter int OUT_W = 27
) (
  input  logic [OUT_W-1:0] i_acc_in,
  input  bcd_digit_t       i_digit,
  output logic [OUT_W-1:0] o_acc_out,
  output logic             o_bad
);

  logic [OUT_W+3:0] w_acc_ext;
  logic [OUT_W+3:0] w_times10;
  logic [OUT_W+3:0] w_sum;
  bcd_digit_t       w_digit_eff;
  logic             w_unused_hi;

  // x*10 as x*8 + x*2, kept four bits wider before the modulo truncation.
  assign w_acc_ext = {4'b0000, i_acc_in};
  assign w_times10 = (w_acc_ext << 3) + (w_acc_ext << 1);

`ifdef BCD_DIGIT_CHECK_EN
  assign o_bad       = (i_digit > BCD_MAX_DIGIT);
  assign w_digit_eff = o_bad ? BCD_MAX_DIGIT : i_digit;
`else
  assign o_bad       = 1'b0;
  assign w_digit_eff = i_digit;
`endif

  assign w_sum     = w_times10 + {{OUT_W{1'b0}}, w_digit_eff};
  assign o_acc_out = w_sum[OUT_W-1:0];

  // Bits above OUT_W are dropped on purpose: wrap-around is modulo 2^OUT_W.
  assign w_unused_hi = ^w_sum[OUT_W+3:OUT_W];

endmodule

// File: rtl/bcd_number_encoder.sv
// ---------------------------------------------------------------------------
// bcd_number_encoder
// Converts a packed BCD word into a binary value, one digit per cycle,
// most significant digit first (acc = acc*10 + digit).
// Optional feature macro: BCD_DIGIT_CHECK_EN (digit range check + clamp).
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   i_in_valid, o_in_ready : input handshake
//   i_in_bcd [4*N_DIGITS]  : digit i at [4*i +: 4]
//   o_out_valid, i_out_ready : output handshake
//   o_out_data [OUT_W]     : binary result, held until the next result
//   o_out_err              : a digit of the word exceeded 9 (feature only)
// ---------------------------------------------------------------------------
module bcd_number_encoder
  import bcd_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int OUT_W    = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [4*N_DIGITS-1:0] i_in_bcd,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [OUT_W-1:0]      o_out_data,
  output logic                  o_out_err
);

  localparam int             CNT_W    = cnt_width(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_DIGITS - 1);

  enc_state_t            r_state;
  enc_state_t            w_state_next;
  logic [4*N_DIGITS-1:0] r_word;
  logic [OUT_W-1:0]      r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_err;
  logic [OUT_W-1:0]      r_out_data;
  logic                  r_out_err;

  logic                  w_accept;
  logic                  w_last;
  bcd_digit_t            w_digits [N_DIGITS];
  logic [OUT_W-1:0]      w_acc_next;
  logic                  w_bad;

  // Unpack the captured word so the current digit is a plain array lookup.
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digits
    assign w_digits[g] = r_word[4*g +: 4];
  end

  bcd_mac_step #(
    .OUT_W (OUT_W)
  ) u_mac_step (
    .i_acc_in  (r_acc),
    .i_digit   (w_digits[r_cnt]),
    .o_acc_out (w_acc_next),
    .o_bad     (w_bad)
  );

  assign w_last = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        o_in_ready = 1'b1;
        w_accept   = i_in_valid;
        if (i_in_valid) begin
          w_state_next = CONV;
        end
      end
      CONV: begin
        if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: capture on handshake, accumulate in CONV, publish the final
  // accumulator together with the sticky error only after the last digit,
  // so a partial result never reaches the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word     <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_out_data <= '0;
      r_out_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_word <= i_in_bcd;
        r_acc  <= '0;
        r_err  <= 1'b0;
        r_cnt  <= CNT_LAST;
      end else if (r_state == CONV) begin
        r_acc <= w_acc_next;
        r_err <= r_err | w_bad;
        r_cnt <= r_cnt - 1'b1;
        if (w_last) begin
          r_out_data <= w_acc_next;
          r_out_err  <= r_err | w_bad;
        end
      end
    end
  end

  assign o_out_data = r_out_data;
  assign o_out_err  = r_out_err;

endmodule

// File: tb/tb_bcd_number_encoder.sv
// ---------------------------------------------------------------------------
// tb_bcd_number_encoder
// Self-checking bench for bcd_number_encoder (default N_DIGITS=8, OUT_W=27).
// Expected results come from a positional decimal model (sum of digit*10^i).
// ---------------------------------------------------------------------------
module tb_bcd_number_encoder;

  localparam int N_DIGITS = 8;
  localparam int OUT_W    = 27;
  localparam int BCD_W    = 4 * N_DIGITS;

  logic             clk;
  logic             rstN;
  logic             inValid;
  logic             inReady;
  logic [BCD_W-1:0] inBcd;
  logic             outValid;
  logic             outReady;
  logic [OUT_W-1:0] outData;
  logic             outErr;

  int nCompare;
  int nFail;

  logic [BCD_W-1:0] streamWords [8];
  logic [OUT_W-1:0] heldData;
  logic             hs;
  int               lat;
  int               sent;
  int               got;
  int               cyc;
  int               lastOut;

  bcd_number_encoder #(
    .N_DIGITS (N_DIGITS),
    .OUT_W    (OUT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rstN),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_in_bcd    (inBcd),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_out_data  (outData),
    .o_out_err   (outErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: positional decimal value, reduced modulo 2^OUT_W.
  function automatic logic [OUT_W-1:0] refValue(input logic [BCD_W-1:0] w);
    longint total = 0;
    longint place = 1;
    longint d;
    for (int i = 0; i < N_DIGITS; i++) begin
      d = longint'(w[4*i +: 4]);
`ifdef BCD_DIGIT_CHECK_EN
      if (d > 9) d = 9;
`endif
      total = total + d * place;
      place = place * 10;
    end
    return OUT_W'(total % (longint'(1) << OUT_W));
  endfunction

  function automatic logic refErr(input logic [BCD_W-1:0] w);
    logic e = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
    for (int i = 0; i < N_DIGITS; i++) begin
      if (w[4*i +: 4] > 4'd9) e = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nCompare++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Offer a word and complete the handshake; leaves time at #1 after the
  // handshake edge with in_valid dropped and in_bcd scrambled.
  task automatic applyStimulus(input logic [BCD_W-1:0] word);
    int guard = 0;
    inValid = 1'b1;
    inBcd   = word;
    while (!inReady && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("handshake_ready", 64'(inReady), 64'd1);
    @(posedge clk); #1;
    inValid = 1'b0;
    inBcd   = $urandom;
  endtask

  task automatic waitResult(output int latency);
    latency = 0;
    while (!outValid && latency < 50) begin
      @(posedge clk); #1;
      latency++;
    end
  endtask

  task automatic runWord(input string tag, input logic [BCD_W-1:0] word);
    int l;
    applyStimulus(word);
    waitResult(l);
    checkOutput({tag, "_latency"}, 64'(l), 64'(N_DIGITS));
    checkOutput({tag, "_data"}, 64'(outData), 64'(refValue(word)));
    checkOutput({tag, "_err"}, 64'(outErr), 64'(refErr(word)));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [BCD_W-1:0] w;
    nCompare = 0;
    nFail    = 0;
    rstN     = 1'b0;
    inValid  = 1'b0;
    inBcd    = '0;
    outReady = 1'b1;

    // Reset state
    #1;
    checkOutput("reset_in_ready", 64'(inReady), 64'd1);
    checkOutput("reset_out_valid", 64'(outValid), 64'd0);
    checkOutput("reset_out_data", 64'(outData), 64'd0);
    checkOutput("reset_out_err", 64'(outErr), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;

    // Basic conversion with one-cycle valid pulse
    applyStimulus(32'h12345678);
    waitResult(lat);
    checkOutput("basic_latency", 64'(lat), 64'd8);
    checkOutput("basic_data", 64'(outData), 64'd12345678);
    checkOutput("basic_err", 64'(outErr), 64'd0);
    @(posedge clk); #1;
    checkOutput("basic_pulse", 64'(outValid), 64'd0);
    checkOutput("basic_ready_back", 64'(inReady), 64'd1);

    // Largest decimal value and zero
    applyStimulus(32'h99999999);
    waitResult(lat);
    checkOutput("max_data", 64'(outData), 64'h5F5E0FF);
    @(posedge clk); #1;
    applyStimulus(32'h00000000);
    waitResult(lat);
    checkOutput("zero_data", 64'(outData), 64'd0);
    @(posedge clk); #1;

    // Back-pressure in DONE: outputs stable, new words ignored
    outReady = 1'b0;
    applyStimulus(32'h00031415);
    waitResult(lat);
    heldData = outData;
    checkOutput("hold_data_first", 64'(heldData), 64'd31415);
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1;
      inBcd   = $urandom;
      @(posedge clk); #1;
      checkOutput("hold_valid", 64'(outValid), 64'd1);
      checkOutput("hold_data", 64'(outData), 64'(heldData));
      checkOutput("hold_in_ready", 64'(inReady), 64'd0);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_valid", 64'(outValid), 64'd0);
    checkOutput("release_in_ready", 64'(inReady), 64'd1);

    // Invalid digit handling
    applyStimulus(32'h0000001A);
    waitResult(lat);
`ifdef BCD_DIGIT_CHECK_EN
    checkOutput("bad_digit_data", 64'(outData), 64'd19);
    checkOutput("bad_digit_err", 64'(outErr), 64'd1);
`else
    checkOutput("bad_digit_data", 64'(outData), 64'd20);
    checkOutput("bad_digit_err", 64'(outErr), 64'd0);
`endif
    @(posedge clk); #1;

    // Reset during conversion after three digits
    applyStimulus(32'h87654321);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    rstN = 1'b0;
    #1;
    checkOutput("midrst_in_ready", 64'(inReady), 64'd1);
    checkOutput("midrst_out_valid", 64'(outValid), 64'd0);
    checkOutput("midrst_out_data", 64'(outData), 64'd0);
    checkOutput("midrst_out_err", 64'(outErr), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_after_ready", 64'(inReady), 64'd1);
    checkOutput("midrst_after_valid", 64'(outValid), 64'd0);
    applyStimulus(32'h00000042);
    waitResult(lat);
    checkOutput("post_reset_data", 64'(outData), 64'd42);
    @(posedge clk); #1;

    // Random words: even ones legal BCD, odd ones arbitrary nibbles
    for (int n = 0; n < 20; n++) begin
      if (n % 2 == 0) begin
        for (int i = 0; i < N_DIGITS; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
      end else begin
        w = $urandom;
      end
      runWord("rand", w);
      @(posedge clk); #1;
    end

    // Streaming: in_valid and out_ready held high
    for (int i = 0; i < 8; i++) begin
      for (int d = 0; d < N_DIGITS; d++) streamWords[i][4*d +: 4] = 4'($urandom_range(0, 9));
    end
    sent     = 0;
    got      = 0;
    cyc      = 0;
    lastOut  = -1;
    outReady = 1'b1;
    inValid  = 1'b1;
    inBcd    = streamWords[0];
    while (got < 8 && cyc < 500) begin
      hs = inValid && inReady;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        sent++;
        if (sent < 8) begin
          inBcd = streamWords[sent];
        end else begin
          inValid = 1'b0;
          inBcd   = $urandom;
        end
      end
      if (outValid) begin
        checkOutput("stream_data", 64'(outData), 64'(refValue(streamWords[got])));
        if (lastOut >= 0) checkOutput("stream_spacing", 64'(cyc - lastOut), 64'(N_DIGITS + 2));
        lastOut = cyc;
        got++;
      end
    end
    checkOutput("stream_received", 64'(got), 64'd8);
    checkOutput("stream_sent", 64'(sent), 64'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompare, nFail);
    $finish;
  end

endmodule

// File: doc/bcd_number_encoder.md
Name: bcd_number_encoder

Overview:
- Converts a packed BCD digit word back into a binary value. This is the opposite direction of the board's binary-to-seven-segment-digit decoder.
- Sits between the FPGA switch/keypad digit-entry logic and the core parameter registers (scores, lengths).
- Iterative: one digit per cycle, MSD first, using acc = acc*10 + digit.
- valid/ready handshake on both sides.

Parameters:
- N_DIGITS, 8, number of BCD digits in the input word (digit 0 = least significant, bits [3:0]).
- OUT_W, 27, width of the binary result. With the default, 99,999,999 fits without loss.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  input word offered
- in_ready  output  1  block can accept a word
- in_bcd  input  4*N_DIGITS  packed BCD digits, digit i at [4*i +: 4]
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_data  output  OUT_W  binary result
- out_err  output  1  a digit was >9 (only meaningful with the optional feature; otherwise constant 0)

Behaviour:
- Reset values (asynchronous): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0, accumulator=0, digit counter=0, captured word=0.
- Reset mid-conversion aborts the conversion. No partial result is ever presented.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, capture in_bcd, clear acc and err, set cnt=N_DIGITS-1, go to CONV.
  - CONV: in_ready=0. Each cycle: acc <= (acc*10 + digit[cnt]) mod 2^OUT_W; cnt <= cnt-1. When cnt==0 is processed, load out_data<=new acc and out_err, then go to DONE.
  - DONE: out_valid=1, out_data/out_err held stable. On out_ready go to IDLE (in_ready rises the next cycle).
- Latency: the handshake at edge k gives out_valid=1 from edge k+N_DIGITS.
- Throughput: at most one word per N_DIGITS+2 cycles with out_ready held high.
- Arithmetic:
  - acc*10 is implemented as (acc<<3)+(acc<<1), computed at OUT_W+4 bits and truncated to OUT_W.
  - Truncation can only matter when invalid digits are present or OUT_W is undersized. Wrap-around is modulo 2^OUT_W and is not flagged.
- Simultaneity: in_valid is ignored outside IDLE, and the captured word is unaffected by in_bcd changes after the handshake. out_ready while out_valid=0 has no effect.
- out_data is undefined-free: it holds the last result until the next DONE load.

Optional Feature:
- Macro: BCD_DIGIT_CHECK_EN.
- Defined:
  - Each digit is checked when consumed in CONV; any digit >9 sets a sticky error flag for that word, and out_err reports it in DONE.
  - The offending digit is clamped to 9 for arithmetic, so out_data stays within the decimal range.
- Undefined:
  - No check and no clamp; digits 10–15 are used as raw values.
  - out_err is tied to 0.

Decomposition:
- Package bcd_pkg:
  - typedef bcd_digit_t (logic [3:0])
  - enum enc_state_t {IDLE, CONV, DONE}
  - localparam BCD_MAX_DIGIT=4'd9
  - function clog2-based counter width for N_DIGITS
- Sub-module bcd_mac_step: combinational acc*10+digit with clamp/check.
  - Ports: acc_in[OUT_W], digit[4], acc_out[OUT_W], bad.
  - Parameter OUT_W.
  - Instantiated once in the top.

Test Plan:
- Reset then in_bcd=32'h12345678, out_ready=1 -> out_valid at handshake+8 cycles; out_data=27'd12345678, out_err=0; one-cycle out_valid pulse.
- in_bcd=32'h99999999 -> out_data=99,999,999 (27'h5F5E0FF), no wrap. Then 32'h00000000 -> out_data=0.
- out_ready held 0 for 5 cycles in DONE -> out_valid and out_data stable, in_ready=0, a new in_valid is ignored. After out_ready=1, in_ready=1 the following cycle.
- in_bcd=32'h0000001A:
  - with BCD_DIGIT_CHECK_EN -> out_data=19, out_err=1.
  - without it -> out_data=20, out_err=0.
- Assert rst_n low during CONV (3 digits consumed) -> all outputs return to reset values immediately, in_ready=1 after release. The next word 32'h00000042 -> out_data=42.
- Back-to-back words with in_valid always high and out_ready always high -> each result is correct, spacing is N_DIGITS+2 cycles, and no word is dropped or duplicated.
